// File: rtl/clock_ctrl_pkg.sv
// Shared encodings and limits for the clock time-set controller.
package clock_ctrl_pkg;

    localparam int TIME_W = 7;

    localparam logic [TIME_W-1:0] HOUR_MAX = 7'd23;
    localparam logic [TIME_W-1:0] MIN_MAX  = 7'd59;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2
    } mode_e;

    // Anything at or above the limit (including out-of-range captures) wraps to zero.
    function automatic logic [TIME_W-1:0] wrap_inc(input logic [TIME_W-1:0] value,
                                                   input logic [TIME_W-1:0] max_val);
        return (value >= max_val) ? '0 : value + 1'b1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability debounce, rising-edge press pulse.
module key_debounce #(
    parameter int DEB_CYC = 20
) (
    input  logic clk_1KHZ,
    input  logic rst,
    input  logic key_raw,
    output logic key_level,
    output logic key_press
);

    localparam int CNT_W = $clog2(DEB_CYC + 1);

    logic             sync_1;
    logic             sync_2;
    logic             level_d;
    logic [CNT_W-1:0] stable_cnt;

    always_ff @(posedge clk_1KHZ or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= key_raw;
            sync_2 <= sync_1;
        end
    end

    // The counter only advances while the synchronized input disagrees with the level.
    always_ff @(posedge clk_1KHZ or posedge rst) begin
        if (rst) begin
            key_level  <= 1'b0;
            stable_cnt <= '0;
        end else if (sync_2 == key_level) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CNT_W'(DEB_CYC - 1)) begin
            key_level  <= sync_2;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_1KHZ or posedge rst) begin
        if (rst) begin
            level_d <= 1'b0;
        end else begin
            level_d <= key_level;
        end
    end

    assign key_press = key_level & ~level_d;

endmodule

// File: rtl/clock_set_ctrl.sv
// 1 Hz tick generator and MODE/INC time-set FSM for the HH:MM:SS timekeeper.
// Optional edit abandonment after an idle period: define SET_TIMEOUT_EN.
module clock_set_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int DIV_CYC     = 1000,
    parameter int DEB_CYC     = 20,
    parameter int BLINK_CYC   = 500,
    parameter int TIMEOUT_CYC = 30000
) (
    input  logic              clk_1KHZ,
    input  logic              rst,
    input  logic              key_mode,
    input  logic              key_inc,
    input  logic [TIME_W-1:0] hour_in,
    input  logic [TIME_W-1:0] min_in,
    output logic              tick_1HZ,
    output logic              load,
    output logic [TIME_W-1:0] hour_load,
    output logic [TIME_W-1:0] min_load,
    output logic [TIME_W-1:0] sec_load,
    output logic [1:0]        mode,
    output logic              blink
);

    localparam int DIV_W   = $clog2(DIV_CYC);
    localparam int BLINK_W = $clog2(BLINK_CYC + 1);

    mode_e              state;
    mode_e              next_state;
    logic               mode_press;
    logic               inc_press;
    logic               mode_level;
    logic               inc_level;
    logic               unused_levels;
    logic               timeout;
    logic               capture;
    logic               commit;
    logic               abort;
    logic               bump;
    logic [DIV_W-1:0]   div_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic [TIME_W-1:0]  edit_hour;
    logic [TIME_W-1:0]  edit_min;

    key_debounce #(.DEB_CYC(DEB_CYC)) u_mode_key (
        .clk_1KHZ  (clk_1KHZ),
        .rst       (rst),
        .key_raw   (key_mode),
        .key_level (mode_level),
        .key_press (mode_press)
    );

    key_debounce #(.DEB_CYC(DEB_CYC)) u_inc_key (
        .clk_1KHZ  (clk_1KHZ),
        .rst       (rst),
        .key_raw   (key_inc),
        .key_level (inc_level),
        .key_press (inc_press)
    );

    assign unused_levels = mode_level ^ inc_level;

`ifdef SET_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    logic [IDLE_W-1:0] idle_cnt;

    always_ff @(posedge clk_1KHZ or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (state == MODE_RUN || mode_press || inc_press) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign timeout = (state != MODE_RUN) && (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout;

    assign unused_timeout = TIMEOUT_CYC[0];
    assign timeout        = 1'b0;
`endif

    always_ff @(posedge clk_1KHZ or posedge rst) begin
        if (rst) begin
            state <= MODE_RUN;
        end else begin
            state <= next_state;
        end
    end

    // A MODE press outranks an expiring idle timer in the same cycle.
    always_comb begin
        next_state = state;
        if (mode_press) begin
            case (state)
                MODE_RUN:      next_state = MODE_SET_HOUR;
                MODE_SET_HOUR: next_state = MODE_SET_MIN;
                MODE_SET_MIN:  next_state = MODE_RUN;
                default:       next_state = MODE_RUN;
            endcase
        end else if (timeout) begin
            next_state = MODE_RUN;
        end
    end

    always_comb begin
        mode    = state;
        capture = (state == MODE_RUN) && mode_press;
        commit  = (state == MODE_SET_MIN) && mode_press;
        abort   = timeout && !mode_press;
        bump    = inc_press && !mode_press;
    end

    always_ff @(posedge clk_1KHZ or posedge rst) begin
        if (rst) begin
            edit_hour <= '0;
            edit_min  <= '0;
        end else if (capture) begin
            edit_hour <= hour_in;
            edit_min  <= min_in;
        end else if (abort) begin
            edit_hour <= '0;
            edit_min  <= '0;
        end else if (bump && state == MODE_SET_HOUR) begin
            edit_hour <= wrap_inc(edit_hour, HOUR_MAX);
        end else if (bump && state == MODE_SET_MIN) begin
            edit_min <= wrap_inc(edit_min, MIN_MAX);
        end
    end

    always_ff @(posedge clk_1KHZ or posedge rst) begin
        if (rst) begin
            load <= 1'b0;
        end else begin
            load <= commit;
        end
    end

    // Clearing during the load cycle puts the first tick a full period after load.
    always_ff @(posedge clk_1KHZ or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (load || div_cnt == DIV_W'(DIV_CYC - 1)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick_1HZ = (div_cnt == DIV_W'(DIV_CYC - 1)) && (state == MODE_RUN) && !load;

    always_ff @(posedge clk_1KHZ or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (state == MODE_RUN) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (blink_cnt == BLINK_W'(BLINK_CYC - 1)) begin
            blink_cnt <= '0;
            blink     <= ~blink;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign hour_load = edit_hour;
    assign min_load  = edit_min;
    assign sec_load  = '0;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: expected mode changes and loads are queued by the
// stimulus and popped by a monitor when the DUT presents them.
module tb_clock_set_ctrl;

    localparam int DIV_CYC     = 4;
    localparam int DEB_CYC     = 2;
    localparam int BLINK_CYC   = 3;
    localparam int TIMEOUT_CYC = 50;
    localparam int SETTLE      = 8;

    typedef struct {
        int h;
        int m;
        int s;
    } load_t;

    logic       clk_1KHZ = 1'b0;
    logic       rst;
    logic       key_mode;
    logic       key_inc;
    logic [6:0] hour_in;
    logic [6:0] min_in;
    logic       tick_1HZ;
    logic       load;
    logic [6:0] hour_load;
    logic [6:0] min_load;
    logic [6:0] sec_load;
    logic [1:0] mode;
    logic       blink;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    set_entry_cyc = 0;
    int    last_load_cyc = 0;
    int    load_to_tick = -1;
    bit    wait_tick = 1'b0;
    logic [1:0] prev_mode = 2'd0;
    logic  prev_load = 1'b0;
    int    exp_mode_q[$];
    load_t exp_load_q[$];

    clock_set_ctrl #(
        .DIV_CYC     (DIV_CYC),
        .DEB_CYC     (DEB_CYC),
        .BLINK_CYC   (BLINK_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk_1KHZ  (clk_1KHZ),
        .rst       (rst),
        .key_mode  (key_mode),
        .key_inc   (key_inc),
        .hour_in   (hour_in),
        .min_in    (min_in),
        .tick_1HZ  (tick_1HZ),
        .load      (load),
        .hour_load (hour_load),
        .min_load  (min_load),
        .sec_load  (sec_load),
        .mode      (mode),
        .blink     (blink)
    );

    always #5 clk_1KHZ = ~clk_1KHZ;

    always @(posedge clk_1KHZ) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    task automatic nextCycle();
        @(negedge clk_1KHZ);
        #1;
    endtask

    task automatic applyStimulus(input bit m, input bit i, input int hold);
        key_mode = m;
        key_inc  = i;
        repeat (hold) nextCycle();
        key_mode = 1'b0;
        key_inc  = 1'b0;
        repeat (SETTLE) nextCycle();
    endtask

    // Monitor: pops the scoreboard whenever the DUT changes mode or strobes load.
    always @(negedge clk_1KHZ) begin
        #2;
        if (!rst) begin
            if (mode != prev_mode) begin
                if (exp_mode_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_mode_change actual=%0d expected=%0d at cycle %0d",
                             mode, prev_mode, cyc);
                end else begin
                    checkOutput("mode_change", int'(mode), exp_mode_q.pop_front());
                end
                if (prev_mode == 2'd0) set_entry_cyc = cyc;
            end
            if (mode != 2'd0) checkOutput("tick_in_set_mode", int'(tick_1HZ), 0);
            if (prev_load) checkOutput("load_one_cycle", int'(load), 0);
            if (load) begin
                checkOutput("tick_with_load", int'(tick_1HZ), 0);
                if (exp_load_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_load actual=1 expected=0 at cycle %0d", cyc);
                end else begin
                    load_t e;
                    e = exp_load_q.pop_front();
                    checkOutput("hour_load", int'(hour_load), e.h);
                    checkOutput("min_load", int'(min_load), e.m);
                    checkOutput("sec_load", int'(sec_load), e.s);
                end
                last_load_cyc = cyc;
                wait_tick     = 1'b1;
            end else if (tick_1HZ && wait_tick) begin
                load_to_tick = cyc - last_load_cyc;
                wait_tick    = 1'b0;
            end
        end
        prev_mode = mode;
        prev_load = load;
    end

    initial begin
        #100000;
        errors++;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        rst      = 1'b1;
        key_mode = 1'b0;
        key_inc  = 1'b0;
        hour_in  = 7'd0;
        min_in   = 7'd0;
        repeat (3) nextCycle();

        checkOutput("rst_mode", int'(mode), 0);
        checkOutput("rst_tick", int'(tick_1HZ), 0);
        checkOutput("rst_load", int'(load), 0);
        checkOutput("rst_blink", int'(blink), 0);
        checkOutput("rst_hour_load", int'(hour_load), 0);
        checkOutput("rst_min_load", int'(min_load), 0);
        checkOutput("rst_sec_load", int'(sec_load), 0);

        // Free-running ticks after reset release.
        rst = 1'b0;
        #1;
        for (int i = 0; i < 12; i++) begin
            checkOutput("idle_tick", int'(tick_1HZ), (i % 4 == 3) ? 1 : 0);
            checkOutput("idle_load", int'(load), 0);
            checkOutput("idle_blink", int'(blink), 0);
            nextCycle();
        end

        // Full edit: hour 11 -> 14, minute 59 -> 0 -> 1, then load.
        hour_in = 7'd11;
        min_in  = 7'd59;
        exp_mode_q.push_back(1);
        applyStimulus(1'b1, 1'b0, 4);
        checkOutput("captured_hour", int'(hour_load), 11);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 4);
        checkOutput("edited_hour", int'(hour_load), 14);
        exp_mode_q.push_back(2);
        applyStimulus(1'b1, 1'b0, 4);
        checkOutput("captured_min", int'(min_load), 59);
        applyStimulus(1'b0, 1'b1, 4);
        checkOutput("min_wrap", int'(min_load), 0);
        applyStimulus(1'b0, 1'b1, 4);
        checkOutput("min_after_wrap", int'(min_load), 1);
        exp_mode_q.push_back(0);
        exp_load_q.push_back('{h: 14, m: 1, s: 0});
        load_to_tick = -1;
        applyStimulus(1'b1, 1'b0, 4);
        for (int i = 0; i < 20 && load_to_tick < 0; i++) nextCycle();
        checkOutput("load_to_tick_gap", load_to_tick, DIV_CYC);
        checkOutput("run_after_load", int'(mode), 0);

        // A one-cycle glitch must not register; a long hold registers once.
        hour_in  = 7'd30;
        min_in   = 7'd70;
        key_mode = 1'b1;
        nextCycle();
        key_mode = 1'b0;
        repeat (10) nextCycle();
        checkOutput("glitch_mode", int'(mode), 0);
        exp_mode_q.push_back(1);
        applyStimulus(1'b1, 1'b0, 20);
        checkOutput("held_mode", int'(mode), 1);
        checkOutput("oor_hour_capture", int'(hour_load), 30);
        checkOutput("oor_min_capture", int'(min_load), 70);
        exp_mode_q.push_back(2);
        applyStimulus(1'b1, 1'b0, 4);
        exp_mode_q.push_back(0);
        exp_load_q.push_back('{h: 30, m: 70, s: 0});
        applyStimulus(1'b1, 1'b0, 4);

        // Hour wrap at 23 and blink phase while editing.
        hour_in = 7'd22;
        min_in  = 7'd5;
        exp_mode_q.push_back(1);
        applyStimulus(1'b1, 1'b0, 4);
        checkOutput("captured_hour_22", int'(hour_load), 22);
        for (int i = 0; i < 12; i++) begin
            checkOutput("blink_phase", int'(blink), ((cyc - set_entry_cyc) / BLINK_CYC) % 2);
            nextCycle();
        end
        applyStimulus(1'b0, 1'b1, 4);
        checkOutput("hour_23", int'(hour_load), 23);
        applyStimulus(1'b0, 1'b1, 4);
        checkOutput("hour_wrap", int'(hour_load), 0);
        applyStimulus(1'b0, 1'b1, 4);
        checkOutput("hour_1", int'(hour_load), 1);

        // Simultaneous MODE and INC: mode advances, hour untouched.
        exp_mode_q.push_back(2);
        applyStimulus(1'b1, 1'b1, 4);
        checkOutput("simul_mode", int'(mode), 2);
        checkOutput("simul_hour", int'(hour_load), 1);
        checkOutput("simul_min", int'(min_load), 5);

        // Reset in SET_MIN discards the edit without a load.
        rst = 1'b1;
        #1;
        checkOutput("midedit_rst_mode", int'(mode), 0);
        checkOutput("midedit_rst_blink", int'(blink), 0);
        checkOutput("midedit_rst_load", int'(load), 0);
        checkOutput("midedit_rst_hour", int'(hour_load), 0);
        nextCycle();
        rst = 1'b0;
        repeat (10) nextCycle();
        checkOutput("post_rst_mode", int'(mode), 0);

`ifdef SET_TIMEOUT_EN
        hour_in = 7'd3;
        exp_mode_q.push_back(1);
        exp_mode_q.push_back(0);
        applyStimulus(1'b1, 1'b0, 4);
        for (int i = 0; i < 100 && mode != 2'd0; i++) nextCycle();
        checkOutput("timeout_mode", int'(mode), 0);
        checkOutput("timeout_cycles", cyc - set_entry_cyc, TIMEOUT_CYC);
        repeat (6) nextCycle();
`endif

        checkOutput("mode_queue_drained", exp_mode_q.size(), 0);
        checkOutput("load_queue_drained", exp_load_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
